// File: rtl/game_pkg.sv
// Shared encodings and widths for the scoring back end and its BCD converter.
package game_pkg;

    typedef enum logic [1:0] {
        TITLE = 2'd0,
        PLAY  = 2'd1,
        OVER  = 2'd2
    } game_state_e;

    typedef enum logic [1:0] {
        CV_IDLE  = 2'd0,
        CV_SHIFT = 2'd1,
        CV_DONE  = 2'd2
    } conv_state_e;

    localparam int SCORE_W     = 14;
    localparam int BCD_W       = 16;
    localparam int BCD_DIGITS  = BCD_W / 4;
    localparam int MAX_LEVEL   = 8;
    localparam int LEVEL_W     = 4;
    localparam int CONV_SHIFTS = SCORE_W;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 14'd9999;

    // Double-dabble correction: any digit of 5 or more gets +3 before the next shift.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] acc);
        logic [BCD_W-1:0] r;
        r = acc;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one load edge, one edge per input bit,
// then one edge that commits the finished digits to bcd in a single update.
module bin2bcd_seq
    import game_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [SCORE_W-1:0] bin,
    output logic               busy,
    output logic               done,
    output logic [BCD_W-1:0]   bcd
);

    // Handshake: start is taken (and bin captured) on an edge where busy is low
    // or done is high; done is high for the one cycle whose closing edge writes bcd.

    conv_state_e        state_q, state_d;
    logic [SCORE_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]   acc_q, acc_d;
    logic [BCD_W-1:0]   acc_adj;
    logic [3:0]         cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;

    assign acc_adj = dabble_adjust(acc_q);

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        case (state_q)
            CV_IDLE: begin
                if (start) begin
                    bin_d   = bin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CV_SHIFT;
                end
            end
            CV_SHIFT: begin
                acc_d = {acc_adj[BCD_W-2:0], bin_q[SCORE_W-1]};
                bin_d = {bin_q[SCORE_W-2:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(CONV_SHIFTS - 1)) begin
                    state_d = CV_DONE;
                end
            end
            CV_DONE: begin
                bcd_d   = acc_q;
                state_d = CV_IDLE;
                if (start) begin
                    bin_d   = bin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CV_SHIFT;
                end
            end
            default: begin
                state_d = CV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CV_IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy = (state_q != CV_IDLE);
    assign done = (state_q == CV_DONE);
    assign bcd  = bcd_q;

endmodule

// File: rtl/score_keeper.sv
// Game scoring back end: hit/miss accounting, TITLE/PLAY/OVER sequencing,
// lane speed-shift bus and BCD display value for the seven-segment digits.
module score_keeper
    import game_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int MAX_MISSES  = 8,
    parameter int STREAK_STEP = 10,
    parameter int LEVEL_STEP  = 16,
    parameter int SPEED_STEP  = 20000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [LANES-1:0]   point_flag,
    input  logic [LANES-1:0]   block_gone_flag,
    output logic [1:0]         game_state,
    output logic [SCORE_W-1:0] score_bin,
    output logic [BCD_W-1:0]   score_bcd,
    output logic [7:0]         streak,
    output logic [2:0]         multiplier,
    output logic [3:0]         misses,
    output logic [49:0]        speed_shift
);

    localparam int CNT_W = $clog2(LANES + 1);

    game_state_e        state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [7:0]         streak_q, streak_d;
    logic [3:0]         misses_q, misses_d;
    logic [LANES-1:0]   gone_prev_q, gone_prev_d;
    logic               req_q, pending_q, pending_d;

    logic [CNT_W-1:0]   hits, new_misses;
    logic [LANES-1:0]   gone_rise;
    logic [7:0]         tier;
    logic [2:0]         mult_c;
    logic [5:0]         gain;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_play;
    logic [8:0]         streak_sum;
    logic [7:0]         streak_play;
    logic [4:0]         miss_sum;
    logic [3:0]         misses_play;
    logic [SCORE_W-1:0] level_raw;
    logic [LEVEL_W-1:0] level;

    logic               conv_start, conv_busy, conv_done;
    logic [BCD_W-1:0]   conv_bcd;

    // Only a low-to-high edge of a sticky gone flag is a new miss.
    assign gone_rise = block_gone_flag & ~gone_prev_q;

    always_comb begin
        hits       = '0;
        new_misses = '0;
        for (int i = 0; i < LANES; i++) begin
            hits       = hits + CNT_W'(point_flag[i]);
            new_misses = new_misses + CNT_W'(gone_rise[i]);
        end
    end

    assign tier   = streak_q / 8'(STREAK_STEP);
    assign mult_c = (tier >= 8'd3) ? 3'd4 : (tier[2:0] + 3'd1);

    assign gain       = 6'(hits) * 6'(mult_c);
    assign score_sum  = (SCORE_W+1)'(score_q) + (SCORE_W+1)'(gain);
    assign score_play = (score_sum > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_MAX
                                                              : score_sum[SCORE_W-1:0];

    assign streak_sum  = 9'(streak_q) + 9'(hits);
    assign streak_play = (new_misses != '0)        ? 8'd0 :
                         (streak_sum > 9'd255)     ? 8'd255 : streak_sum[7:0];

    assign miss_sum    = 5'(misses_q) + 5'(new_misses);
    assign misses_play = (miss_sum >= 5'(MAX_MISSES)) ? 4'(MAX_MISSES) : miss_sum[3:0];

    assign level_raw   = score_q / SCORE_W'(LEVEL_STEP);
    assign level       = (level_raw >= SCORE_W'(MAX_LEVEL)) ? LEVEL_W'(MAX_LEVEL)
                                                            : level_raw[LEVEL_W-1:0];

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        streak_d    = streak_q;
        misses_d    = misses_q;
        gone_prev_d = gone_prev_q;
        case (state_q)
            TITLE: begin
                score_d     = '0;
                streak_d    = '0;
                misses_d    = '0;
                gone_prev_d = '0;
                if (start) begin
                    state_d     = PLAY;
                    gone_prev_d = block_gone_flag;
                end
            end
            PLAY: begin
                if (!start) begin
                    state_d     = TITLE;
                    score_d     = '0;
                    streak_d    = '0;
                    misses_d    = '0;
                    gone_prev_d = '0;
                end else begin
                    score_d     = score_play;
                    streak_d    = streak_play;
                    misses_d    = misses_play;
                    gone_prev_d = block_gone_flag;
                    if (misses_play == 4'(MAX_MISSES)) begin
                        state_d = OVER;
                    end
                end
            end
            OVER: begin
                if (!start) begin
                    state_d     = TITLE;
                    score_d     = '0;
                    streak_d    = '0;
                    misses_d    = '0;
                    gone_prev_d = '0;
                end
            end
            default: begin
                state_d     = TITLE;
                score_d     = '0;
                streak_d    = '0;
                misses_d    = '0;
                gone_prev_d = '0;
            end
        endcase
    end

    // A score change that lands while the converter is busy is remembered in
    // one pending bit; the rerun samples whatever score_bin holds by then.
    assign conv_start = (req_q | pending_q) & (~conv_busy | conv_done);

    always_comb begin
        pending_d = pending_q;
        if (conv_start) begin
            pending_d = 1'b0;
        end else if (req_q) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= TITLE;
            score_q     <= '0;
            streak_q    <= '0;
            misses_q    <= '0;
            gone_prev_q <= '0;
            req_q       <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            streak_q    <= streak_d;
            misses_q    <= misses_d;
            gone_prev_q <= gone_prev_d;
            req_q       <= (score_d != score_q);
            pending_q   <= pending_d;
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (conv_start),
        .bin     (score_q),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd     (conv_bcd)
    );

    assign game_state  = state_q;
    assign score_bin   = score_q;
    assign score_bcd   = conv_bcd;
    assign streak      = streak_q;
    assign multiplier  = mult_c;
    assign misses      = misses_q;
    assign speed_shift = 50'(level) * 50'(SPEED_STEP);

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural game model.
module tb_score_keeper;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  point_flag = 4'b0;
    logic [3:0]  block_gone_flag = 4'b0;
    logic [1:0]  game_state;
    logic [13:0] score_bin;
    logic [15:0] score_bcd;
    logic [7:0]  streak;
    logic [2:0]  multiplier;
    logic [3:0]  misses;
    logic [49:0] speed_shift;

    int n_cmp = 0;
    int n_err = 0;
    bit run_check = 1'b0;

    // Behavioural model state
    int         m_state, m_score, m_streak, m_misses, m_stable;
    logic [3:0] m_prev;
    int         m_old, m_hits, m_new, m_mult;
    logic [15:0] exp_q[$];

    score_keeper dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .point_flag      (point_flag),
        .block_gone_flag (block_gone_flag),
        .game_state      (game_state),
        .score_bin       (score_bin),
        .score_bcd       (score_bcd),
        .streak          (streak),
        .multiplier      (multiplier),
        .misses          (misses),
        .speed_shift     (speed_shift)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_score  = 0;
        m_streak = 0;
        m_misses = 0;
        m_prev   = 4'b0;
    endtask

    // Game rules applied once per clock edge to the inputs the DUT sampled.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_state  = 0;
            model_clear();
            m_stable = 1000;
            exp_q    = {};
            exp_q.push_back(16'h0000);
        end else begin
            m_old = m_score;
            case (m_state)
                0: if (start) begin
                    m_state = 1;
                    model_clear();
                    m_prev = block_gone_flag;
                end
                1: if (!start) begin
                    m_state = 0;
                    model_clear();
                end else begin
                    m_hits   = $countones(point_flag);
                    m_new    = $countones(block_gone_flag & ~m_prev);
                    m_prev   = block_gone_flag;
                    m_mult   = 1 + min_i(3, m_streak / 10);
                    m_score  = min_i(9999, m_score + m_hits * m_mult);
                    if (m_new > 0) begin
                        m_streak = 0;
                        m_misses = min_i(8, m_misses + m_new);
                    end else begin
                        m_streak = min_i(255, m_streak + m_hits);
                    end
                    if (m_misses == 8) m_state = 2;
                end
                default: if (!start) begin
                    m_state = 0;
                    model_clear();
                end
            endcase
            if (m_score != m_old) begin
                m_stable = 0;
                exp_q.push_back(to_bcd(m_score));
                if (exp_q.size() > 64) void'(exp_q.pop_front());
            end else if (m_stable < 1000) begin
                m_stable++;
            end
        end
    end

    // Per-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (run_check && reset_n) begin
            bit found;
            chk("game_state", game_state, m_state);
            chk("score_bin", score_bin, m_score);
            chk("streak", streak, m_streak);
            chk("misses", misses, m_misses);
            chk("multiplier", multiplier, 1 + min_i(3, m_streak / 10));
            chk("speed_shift", speed_shift, longint'(min_i(8, m_score / 16)) * 20000);
            found = 1'b0;
            foreach (exp_q[i]) if (exp_q[i] == score_bcd) found = 1'b1;
            chk("score_bcd_atomic", found, 1);
            if (m_stable >= 32) chk("score_bcd_settled", score_bcd, to_bcd(m_score));
        end
    end

    task automatic drive(input logic [3:0] pf, input logic [3:0] g, input logic st);
        point_flag      = pf;
        block_gone_flag = g;
        start           = st;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(4'b0000, block_gone_flag, start);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] pf, g;
        logic       st;
        int         dens;

        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", game_state, 0);
        chk("reset_score", score_bin, 0);
        chk("reset_bcd", score_bcd, 0);
        chk("reset_streak", streak, 0);
        chk("reset_mult", multiplier, 1);
        chk("reset_misses", misses, 0);
        chk("reset_speed", speed_shift, 0);
        reset_n   = 1'b1;
        run_check = 1'b1;

        drive(4'b0000, 4'b0000, 1'b0);
        drive(4'b0000, 4'b0000, 1'b1);
        chk("enter_play", game_state, 1);
        drive(4'b0001, 4'b0000, 1'b1);
        chk("first_hit_score", score_bin, 1);
        chk("first_hit_streak", streak, 1);
        chk("first_hit_mult", multiplier, 1);
        for (int k = 1; k <= 16; k++) begin
            drive(4'b0000, 4'b0000, 1'b1);
            if (k == 15) chk("bcd_before_16", score_bcd, 16'h0000);
            if (k == 16) chk("bcd_at_16", score_bcd, 16'h0001);
        end

        repeat (9) drive(4'b0001, 4'b0000, 1'b1);
        chk("ten_hits_score", score_bin, 10);
        chk("ten_hits_streak", streak, 10);
        chk("ten_hits_mult", multiplier, 2);
        drive(4'b0001, 4'b0000, 1'b1);
        chk("eleventh_hit_score", score_bin, 12);
        chk("eleventh_hit_streak", streak, 11);

        drive(4'b0001, 4'b0100, 1'b1);
        chk("hit_miss_score", score_bin, 14);
        chk("hit_miss_streak", streak, 0);
        chk("hit_miss_misses", misses, 1);
        chk("hit_miss_mult", multiplier, 1);
        repeat (3) drive(4'b0000, 4'b0100, 1'b1);
        chk("sticky_no_recount", misses, 1);

        drive(4'b1111, 4'b0100, 1'b1);
        chk("quad_score", score_bin, 18);
        chk("quad_streak", streak, 4);
        chk("quad_speed", speed_shift, 20000);

        drive(4'b0000, 4'b0000, 1'b1);
        drive(4'b0000, 4'b1111, 1'b1);
        chk("four_misses", misses, 5);
        drive(4'b0000, 4'b0000, 1'b1);
        drive(4'b0000, 4'b0111, 1'b1);
        chk("over_state", game_state, 2);
        chk("over_misses", misses, 8);
        repeat (2) begin
            drive(4'b1111, 4'b1000, 1'b1);
            drive(4'b1111, 4'b0000, 1'b1);
        end
        chk("over_frozen_score", score_bin, 18);
        chk("over_frozen_state", game_state, 2);

        drive(4'b0000, 4'b0000, 1'b0);
        chk("back_to_title", game_state, 0);
        idle(40);
        chk("title_score", score_bin, 0);
        chk("title_bcd", score_bcd, 0);
        chk("title_streak", streak, 0);
        chk("title_misses", misses, 0);
        chk("title_mult", multiplier, 1);
        chk("title_speed", speed_shift, 0);

        drive(4'b0000, 4'b1111, 1'b1);
        chk("restart_state", game_state, 1);
        drive(4'b0000, 4'b1111, 1'b1);
        chk("stale_gone_ignored", misses, 0);

        repeat (9) drive(4'b0001, 4'b1111, 1'b1);
        drive(4'b0011, 4'b1111, 1'b1);
        repeat (8) drive(4'b0001, 4'b1111, 1'b1);
        drive(4'b0011, 4'b1111, 1'b1);
        repeat (9) drive(4'b0001, 4'b1111, 1'b1);
        chk("ramp_score", score_bin, 58);
        chk("ramp_streak", streak, 30);
        chk("ramp_mult", multiplier, 4);
        chk("ramp_speed", speed_shift, 60000);

        repeat (621) drive(4'b1111, 4'b1111, 1'b1);
        drive(4'b0001, 4'b1111, 1'b1);
        chk("near_max_score", score_bin, 9998);
        chk("near_max_mult", multiplier, 4);
        chk("streak_sat", streak, 255);
        drive(4'b0001, 4'b1111, 1'b1);
        chk("max_score", score_bin, 9999);
        chk("max_speed", speed_shift, 160000);
        drive(4'b0001, 4'b1111, 1'b1);
        chk("score_sat", score_bin, 9999);
        idle(40);
        chk("max_bcd", score_bcd, 16'h9999);

        drive(4'b0000, 4'b1111, 1'b0);
        chk("drop_start_score", score_bin, 0);
        idle(5);
        #2 reset_n = 1'b0;
        #1 chk("abort_bcd", score_bcd, 0);
        chk("abort_score", score_bin, 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        idle(40);
        chk("post_abort_bcd", score_bcd, 0);
        chk("post_abort_state", game_state, 0);

        for (int blk = 0; blk < 20; blk++) begin
            dens = $urandom_range(0, 3);
            for (int c = 0; c < 80; c++) begin
                pf = 4'b0000;
                for (int l = 0; l < 4; l++) begin
                    if (dens != 0 && $urandom_range(0, 9) < dens * 2) pf[l] = 1'b1;
                end
                g = block_gone_flag;
                for (int l = 0; l < 4; l++) begin
                    if ($urandom_range(0, 29) == 0) g[l] = ~g[l];
                end
                st = start;
                if (start && $urandom_range(0, 199) == 0) st = 1'b0;
                else if (!start && $urandom_range(0, 3) == 0) st = 1'b1;
                drive(pf, g, st);
            end
        end
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
